// File: rtl/mem_request_master.sv
// mem_request_master: issues one fetch/load/store to Main_Memory, holds the strobes until Done,
// then reports completion with a one-cycle pulse. Define MEM_TIMEOUT_EN to abort stalled accesses.
module mem_request_master #(
    parameter int unsigned ADDR_W         = 13,
    parameter int unsigned DATA_W         = 13,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_instr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataIn,
    output logic              mem_write,
    output logic              mem_read,
    output logic              mem_instruction,
    input  logic [DATA_W-1:0] mem_dataOut,
    input  logic              mem_Done
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                busy_q, busy_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                wr_q, wr_d;
    logic                rd_q, rd_d;
    logic                instr_q, instr_d;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rsp_err_q, rsp_err_d;
    logic            timeout;

    // cnt_q counts ACCESS cycles already spent without Done
    assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        addr_d      = addr_q;
        din_d       = din_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        instr_d     = instr_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d     = StAccess;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    addr_d      = req_addr;
                    din_d       = req_wdata;
                    // a fetch is always a read, even if req_write is set
                    wr_d        = req_write & ~req_instr;
                    rd_d        = ~(req_write & ~req_instr);
                    instr_d     = req_instr;
`ifdef MEM_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            StAccess: begin
                if (mem_Done) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    wr_d        = 1'b0;
                    rd_d        = 1'b0;
                    instr_d     = 1'b0;
                    if (rd_q) begin
                        rsp_rdata_d = mem_dataOut;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    wr_d        = 1'b0;
                    rd_d        = 1'b0;
                    instr_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            StResp: begin
                state_d     = StIdle;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            default: begin
                state_d     = StIdle;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                wr_d        = 1'b0;
                rd_d        = 1'b0;
                instr_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            instr_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            instr_q     <= instr_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign req_ready       = req_ready_q;
    assign busy            = busy_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign mem_address     = addr_q;
    assign mem_dataIn      = din_q;
    assign mem_write       = wr_q;
    assign mem_read        = rd_q;
    assign mem_instruction = instr_q;
`ifdef MEM_TIMEOUT_EN
    assign rsp_err         = rsp_err_q;
`else
    assign rsp_err         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_request_master.sv
// Bench for mem_request_master: directed scenarios plus randomized traffic against a
// transaction-level model; honours MEM_TIMEOUT_EN the same way the design does.
module tb_mem_request_master;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_instr;
    logic [12:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [12:0] rsp_rdata;
    logic [12:0] mem_address, mem_dataIn, mem_dataOut;
    logic        mem_write, mem_read, mem_instruction, mem_Done;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // responder controls
    int done_at    = 1;
    bit never_done = 1'b0;
    bit spurious   = 1'b0;
    bit rand_delay = 1'b0;
    int rand_max   = 6;
    logic [12:0] mem_arr [0:8191];

    always #5 clk = ~clk;

    mem_request_master dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_instr       (req_instr),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .busy            (busy),
        .mem_address     (mem_address),
        .mem_dataIn      (mem_dataIn),
        .mem_write       (mem_write),
        .mem_read        (mem_read),
        .mem_instruction (mem_instruction),
        .mem_dataOut     (mem_dataOut),
        .mem_Done        (mem_Done)
    );

    // Main_Memory stand-in: Done on the target-th strobe cycle, random data otherwise
    initial begin : responder
        int acc_k;
        int target;
        bit hit;
        for (int i = 0; i < 8192; i++) mem_arr[i] = 13'(i * 7 + 3);
        mem_arr[5] = 13'h0ABC;
        mem_arr[0] = 13'h0123;
        mem_Done    = 1'b0;
        mem_dataOut = '0;
        acc_k  = 0;
        target = 1;
        forever begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                acc_k++;
                if (acc_k == 1) target = rand_delay ? int'($urandom_range(1, rand_max)) : done_at;
                hit = !never_done && (acc_k == target);
            end else begin
                acc_k = 0;
                hit   = spurious && ($urandom_range(0, 3) == 0);
            end
            mem_Done    = hit;
            mem_dataOut = (hit && mem_read) ? mem_arr[mem_address] : 13'($urandom);
            if (hit && mem_write) mem_arr[mem_address] = mem_dataIn;
        end
    end

    // Transaction-level model: one outstanding request, then a single response cycle
    initial begin : model_cmp
        bit          m_live, m_resp, m_wr, m_instr, m_err;
        int          waited;
        logic [12:0] m_addr, m_wdata, m_rdata;
        logic [45:0] exp_v, got_v;
        m_live = 0; m_resp = 0; m_wr = 0; m_instr = 0; m_err = 0; waited = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_live = 0; m_resp = 0; m_wr = 0; m_instr = 0; m_err = 0;
                m_addr = '0; m_wdata = '0; m_rdata = '0;
            end else if (m_resp) begin
                m_resp = 0;
            end else if (m_live) begin
                if (mem_Done) begin
                    m_live = 0; m_resp = 1; m_err = 0;
                    if (!m_wr) m_rdata = mem_dataOut;
                end
`ifdef MEM_TIMEOUT_EN
                else if (waited + 1 == int'(TO)) begin
                    m_live = 0; m_resp = 1; m_err = 1; m_rdata = '0;
                end
`endif
                else waited++;
            end else if (req_valid) begin
                m_live  = 1;
                waited  = 0;
                m_addr  = req_addr;
                m_wdata = req_wdata;
                m_wr    = req_write && !req_instr;
                m_instr = req_instr;
            end
            #1;
            exp_v = {!m_live && !m_resp, m_live || m_resp, m_live && !m_wr, m_live && m_wr,
                     m_live && m_instr, m_addr, m_wdata, m_resp, m_rdata, m_resp && m_err};
            got_v = {req_ready, busy, mem_read, mem_write, mem_instruction, mem_address,
                     mem_dataIn, rsp_valid, rsp_rdata, rsp_err};
            n_vec++;
            if (got_v !== exp_v) begin
                n_bad++;
                $display("FAIL cycle_%0d outputs {rdy,busy,rd,wr,ins,addr,din,rv,rdata,err}: got %h, required %h",
                         cyc, got_v, exp_v);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Issue one request from IDLE and observe it until rsp_valid (called at a negedge).
    task automatic run_txn(input string name, input logic w, input logic ins,
                           input logic [12:0] a, input logic [12:0] wd,
                           output int rdc, output int wrc, output int insc,
                           output logic [12:0] din_seen, output int lat,
                           output logic [12:0] rdata, output logic err);
        req_valid = 1'b1; req_write = w; req_instr = ins; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        rdc = 0; wrc = 0; insc = 0; lat = 0; din_seen = '0; rdata = '0; err = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            if (rsp_valid) begin
                lat = k; rdata = rsp_rdata; err = rsp_err;
                break;
            end
            rdc += int'(mem_read);
            wrc += int'(mem_write);
            insc += int'(mem_instruction);
            if (mem_write) din_seen = mem_dataIn;
            @(negedge clk);
        end
        if (lat == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_wait: got no rsp_valid in 64 cycles, required a response", name);
        end
    endtask

    initial begin : stim
        int rdc, wrc, insc, lat, rv_k, w_k;
        logic [12:0] din_seen, rdat, wa, wdd;
        logic err;
        int rv_seen;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_instr = 1'b0;
        req_addr = '0; req_wdata = '0;
        tick(2);
        check("reset_req_ready", req_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_strobes", {mem_read, mem_write, mem_instruction}, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        reset = 1'b0;

        // 1: read with Done on the third access cycle
        done_at = 3;
        run_txn("t1", 0, 0, 13'h005, 13'h0, rdc, wrc, insc, din_seen, lat, rdat, err);
        check("t1_read_cycles", rdc, 3);
        check("t1_write_cycles", wrc, 0);
        check("t1_latency", lat, 4);
        check("t1_rdata", rdat, 13'h0ABC);
        tick(1);
        check("t1_ready_after", req_ready, 1);
        check("t1_rsp_one_cycle", rsp_valid, 0);

        // 2: write then read back; rdata must hold across the write
        done_at = 2;
        run_txn("t2w", 1, 0, 13'h1F0, 13'h10F0, rdc, wrc, insc, din_seen, lat, rdat, err);
        check("t2_write_cycles", wrc, 2);
        check("t2_read_cycles", rdc, 0);
        check("t2_dataIn", din_seen, 13'h10F0);
        check("t2_rdata_held", rdat, 13'h0ABC);
        tick(1);
        done_at = 1;
        run_txn("t2r", 0, 0, 13'h1F0, 13'h0, rdc, wrc, insc, din_seen, lat, rdat, err);
        check("t2_readback", rdat, 13'h10F0);
        tick(1);

        // 3: fetch with req_write set is a read
        run_txn("t3", 1, 1, 13'h000, 13'h1555, rdc, wrc, insc, din_seen, lat, rdat, err);
        check("t3_read_cycles", rdc, 1);
        check("t3_write_cycles", wrc, 0);
        check("t3_instr_cycles", insc, 1);
        check("t3_rdata", rdat, 13'h0123);
        check("t3_mem0_kept", mem_arr[0], 13'h0123);
        tick(1);

        // 4: reset during the second access cycle
        done_at = 5;
        req_valid = 1'b1; req_write = 1'b0; req_instr = 1'b0; req_addr = 13'h003;
        tick(1);
        req_valid = 1'b0;
        tick(1);
        check("t4_reading", mem_read, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t4_strobes_low", {mem_read, mem_write, mem_instruction}, 0);
        check("t4_ready", req_ready, 1);
        check("t4_busy", busy, 0);
        rv_seen = 0;
        for (int k = 0; k < 8; k++) begin
            rv_seen += int'(rsp_valid);
            tick(1);
        end
        check("t4_no_rsp", rv_seen, 0);

        // 5: Done ignored while idle, minimum latency, held request waits for RESP
        spurious = 1'b1;
        tick(6);
        spurious = 1'b0;
        check("t5_idle_ready", req_ready, 1);
        check("t5_idle_busy", busy, 0);
        done_at = 1;
        run_txn("t5a", 0, 0, 13'h007, 13'h0, rdc, wrc, insc, din_seen, lat, rdat, err);
        check("t5_min_latency", lat, 2);
        check("t5_rdata", rdat, mem_arr[7]);
        tick(1);
        done_at = 3;
        req_valid = 1'b1; req_write = 1'b0; req_instr = 1'b0; req_addr = 13'h00A;
        tick(1);
        req_write = 1'b1; req_addr = 13'h00B; req_wdata = 13'h0777;
        rv_k = 0; w_k = 0; wa = '0; wdd = '0;
        for (int k = 1; k <= 32; k++) begin
            if (rsp_valid && rv_k == 0) rv_k = k;
            if (mem_write) begin
                w_k = k; wa = mem_address; wdd = mem_dataIn;
                break;
            end
            tick(1);
        end
        req_valid = 1'b0;
        check("t5_first_rsp_cycle", rv_k, 4);
        check("t5_held_accept_gap", w_k - rv_k, 2);
        check("t5_held_addr", wa, 13'h00B);
        check("t5_held_data", wdd, 13'h0777);
        for (int k = 0; k < 32; k++) begin
            if (rsp_valid) break;
            tick(1);
        end
        tick(1);

        // 6: Done never arrives
        never_done = 1'b1;
`ifdef MEM_TIMEOUT_EN
        run_txn("t6", 0, 0, 13'h009, 13'h0, rdc, wrc, insc, din_seen, lat, rdat, err);
        check("t6_read_cycles", rdc, TO);
        check("t6_latency", lat, TO + 1);
        check("t6_err", err, 1);
        check("t6_rdata_zero", rdat, 0);
        tick(1);
        check("t6_err_cleared", rsp_err, 0);
        never_done = 1'b0;
`else
        req_valid = 1'b1; req_write = 1'b0; req_instr = 1'b0; req_addr = 13'h009;
        tick(1);
        req_valid = 1'b0;
        tick(40);
        check("t6_still_busy", busy, 1);
        check("t6_still_reading", mem_read, 1);
        check("t6_no_err", rsp_err, 0);
        never_done = 1'b0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
`endif

        // randomized traffic; the model process checks every cycle
        rand_delay = 1'b1;
        spurious   = 1'b1;
`ifdef MEM_TIMEOUT_EN
        rand_max = 20;
`else
        rand_max = 6;
`endif
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            req_valid = ($urandom_range(0, 2) != 0);
            req_write = $urandom_range(0, 1) == 1;
            req_instr = ($urandom_range(0, 3) == 0);
            req_addr  = 13'($urandom_range(0, 15));
            req_wdata = 13'($urandom);
            tick(1);
        end
        reset = 1'b0;
        req_valid = 1'b0;
        tick(40);
        check("end_idle_ready", req_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
